// File: rtl/cross_bar_arbiter.sv
// Per-slave round-robin arbiter steering crossbar mux selects; optional watchdog under CROSS_BAR_TIMEOUT_EN.
// Latency: grant 1 cycle after request, release 1 cycle after ack.
// Backpressure: none; requests are held until ack, a busy slave defers other candidates.

package cross_bar_pkg;
    localparam int MASTER_N = 4;
    localparam int SLAVE_N  = 4;
    localparam int ADDR_W   = 32;
    localparam int SEL_W    = $clog2(SLAVE_N);
    typedef logic [ADDR_W-1:0]                addr_t;
    typedef logic [$clog2(MASTER_N+1)-1:0]    master_num_t;
    typedef logic [$clog2(SLAVE_N+1)-1:0]     slave_num_t;
endpackage

module cross_bar_arbiter
    import cross_bar_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic        [MASTER_N:1] master_req,
    input  addr_t       [MASTER_N:1] master_addr,
    input  logic        [SLAVE_N:1]  slave_ack,
    output slave_num_t  [MASTER_N:1] master_mux,
    output master_num_t [SLAVE_N:1]  slave_mux
`ifdef CROSS_BAR_TIMEOUT_EN
    ,
    output logic        [SLAVE_N:1]  slave_timeout
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic        [SLAVE_N:1][0:0] state_q, state_d;
    master_num_t [SLAVE_N:1]      last_q, last_d;
    master_num_t [SLAVE_N:1]      slave_mux_q, slave_mux_d;
    slave_num_t  [MASTER_N:1]     master_mux_q, master_mux_d;
    slave_num_t  [MASTER_N:1]     tgt;
    logic        [SLAVE_N:1]      grant;
    logic        [SLAVE_N:1]      release_s;
    logic        [SLAVE_N:1]      gnt_req;
    logic        [SLAVE_N:1]      timeout_hit;
    master_num_t [SLAVE_N:1]      winner;
    logic                         unused_addr_bits;

    // Only the top SEL_W address bits select the slave.
    assign unused_addr_bits = ^master_addr;

    always_comb begin
        tgt = '0;
        for (int m = 1; m <= MASTER_N; m++) begin
            tgt[m] = slave_num_t'(master_addr[m][ADDR_W-1 -: SEL_W]) + slave_num_t'(1);
        end
    end

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        winner    = '0;
        gnt_req   = '0;
        release_s = '0;
        for (int s = 1; s <= SLAVE_N; s++) begin
            // Rotating search starting just after the last served master.
            for (int i = 1; i <= MASTER_N; i++) begin
                idx = ((int'(last_q[s]) + i - 1) % MASTER_N) + 1;
                for (int m = 1; m <= MASTER_N; m++) begin
                    if (state_q[s] == IDLE && !grant[s] && idx == m && master_req[m] &&
                        tgt[m] == slave_num_t'(s) && master_mux_q[m] == '0) begin
                        grant[s]  = 1'b1;
                        winner[s] = master_num_t'(m);
                    end
                end
            end
            for (int m = 1; m <= MASTER_N; m++) begin
                if (slave_mux_q[s] == master_num_t'(m)) begin
                    gnt_req[s] = master_req[m];
                end
            end
            release_s[s] = (state_q[s] == BUSY) &&
                           (slave_ack[s] || !gnt_req[s] || timeout_hit[s]);
        end
    end

    always_comb begin
        state_d     = state_q;
        slave_mux_d = slave_mux_q;
        last_d      = last_q;
        for (int s = 1; s <= SLAVE_N; s++) begin
            if (grant[s]) begin
                state_d[s]     = BUSY;
                slave_mux_d[s] = winner[s];
            end else if (release_s[s]) begin
                state_d[s]     = IDLE;
                slave_mux_d[s] = '0;
                last_d[s]      = slave_mux_q[s];
            end
        end
    end

    // A master can only be granted while its entry is zero, so set and clear never collide.
    always_comb begin
        master_mux_d = master_mux_q;
        for (int s = 1; s <= SLAVE_N; s++) begin
            for (int m = 1; m <= MASTER_N; m++) begin
                if (release_s[s] && slave_mux_q[s] == master_num_t'(m)) begin
                    master_mux_d[m] = '0;
                end
                if (grant[s] && winner[s] == master_num_t'(m)) begin
                    master_mux_d[m] = slave_num_t'(s);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= '0;
            slave_mux_q  <= '0;
            master_mux_q <= '0;
            for (int s = 1; s <= SLAVE_N; s++) begin
                last_q[s] <= master_num_t'(MASTER_N);
            end
        end else begin
            state_q      <= state_d;
            slave_mux_q  <= slave_mux_d;
            master_mux_q <= master_mux_d;
            last_q       <= last_d;
        end
    end

`ifdef CROSS_BAR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [SLAVE_N:1][CNT_W-1:0] cnt_q, cnt_d;
    logic [SLAVE_N:1]            timeout_q, timeout_d;

    always_comb begin
        timeout_hit = '0;
        for (int s = 1; s <= SLAVE_N; s++) begin
            timeout_hit[s] = (state_q[s] == BUSY) && !slave_ack[s] &&
                             (cnt_q[s] == CNT_W'(TIMEOUT_CYCLES - 1));
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_hit;
        for (int s = 1; s <= SLAVE_N; s++) begin
            if (grant[s] || release_s[s]) begin
                cnt_d[s] = '0;
            end else if (state_q[s] == BUSY && !slave_ack[s]) begin
                cnt_d[s] = cnt_q[s] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign slave_timeout = timeout_q;
`else
    assign timeout_hit = '0;
`endif

    assign master_mux = master_mux_q;
    assign slave_mux  = slave_mux_q;

endmodule

// File: tb/tb_cross_bar_arbiter.sv
// Directed bench for cross_bar_arbiter: reset, single transfer, contention, parallel, abort, hold/timeout.
module tb_cross_bar_arbiter;
    import cross_bar_pkg::*;

    logic                     clk;
    logic                     rst_n;
    logic        [MASTER_N:1] master_req;
    addr_t       [MASTER_N:1] master_addr;
    logic        [SLAVE_N:1]  slave_ack;
    slave_num_t  [MASTER_N:1] master_mux;
    master_num_t [SLAVE_N:1]  slave_mux;
`ifdef CROSS_BAR_TIMEOUT_EN
    logic        [SLAVE_N:1]  slave_timeout;
`endif

    int checks = 0;
    int errors = 0;

    cross_bar_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .master_req  (master_req),
        .master_addr (master_addr),
        .slave_ack   (slave_ack),
        .master_mux  (master_mux),
        .slave_mux   (slave_mux)
`ifdef CROSS_BAR_TIMEOUT_EN
        ,
        .slave_timeout(slave_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic addr_t addr_for(input int s);
        addr_t a;
        a = '0;
        a[ADDR_W-1 -: SEL_W] = SEL_W'(s - 1);
        return a;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1;
        master_req  = '0;
        master_addr = '0;
        slave_ack   = '0;
        rst_n       = 1'b0;
        #2;
        rst_n       = 1'b1;
    endtask

    task automatic test_reset;
        master_req  = '0;
        master_addr = '0;
        slave_ack   = '0;
        rst_n       = 1'b1;
        #2;
        rst_n = 1'b0;
        tick();
        checks++;
        if (master_mux !== '0 || slave_mux !== '0) begin
            errors++;
            $display("FAIL reset_initial master_mux=%h slave_mux=%h exp 0", master_mux, slave_mux);
        end
        rst_n = 1'b1;
        master_addr[1] = addr_for(1);
        master_req[1]  = 1'b1;
        tick();
        checks++;
        if (slave_mux[1] !== master_num_t'(1)) begin
            errors++;
            $display("FAIL reset_pregrant slave_mux[1]=%0d exp 1", slave_mux[1]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (master_mux !== '0 || slave_mux !== '0) begin
            errors++;
            $display("FAIL reset_async master_mux=%h slave_mux=%h exp 0", master_mux, slave_mux);
        end
        #1;
        rst_n = 1'b1;
        master_addr[2] = addr_for(1);
        master_req[2]  = 1'b1;
        tick();
        checks++;
        if (slave_mux[1] !== master_num_t'(1) || master_mux[1] !== slave_num_t'(1) ||
            master_mux[2] !== '0) begin
            errors++;
            $display("FAIL reset_priority slave_mux[1]=%0d master_mux[1]=%0d master_mux[2]=%0d exp 1 1 0",
                     slave_mux[1], master_mux[1], master_mux[2]);
        end
    endtask

    task automatic test_single;
        do_reset();
        master_addr[1] = addr_for(2);
        master_req[1]  = 1'b1;
        tick();  // cycle 1
        checks++;
        if (slave_mux[2] !== master_num_t'(1) || master_mux[1] !== slave_num_t'(2)) begin
            errors++;
            $display("FAIL single_grant slave_mux[2]=%0d master_mux[1]=%0d exp 1 2", slave_mux[2], master_mux[1]);
        end
        tick();  // cycle 2
        tick();  // cycle 3
        slave_ack[2] = 1'b1;
        checks++;
        if (slave_mux[2] !== master_num_t'(1)) begin
            errors++;
            $display("FAIL single_hold slave_mux[2]=%0d exp 1", slave_mux[2]);
        end
        tick();  // cycle 4
        slave_ack[2]  = 1'b0;
        master_req[1] = 1'b0;
        checks++;
        if (slave_mux[2] !== '0 || master_mux[1] !== '0) begin
            errors++;
            $display("FAIL single_release slave_mux[2]=%0d master_mux[1]=%0d exp 0 0", slave_mux[2], master_mux[1]);
        end
    endtask

    task automatic test_contention;
        do_reset();
        for (int m = 1; m <= MASTER_N; m++) begin
            master_addr[m] = addr_for(1);
        end
        master_req = '1;
        for (int k = 1; k <= MASTER_N; k++) begin
            tick();  // grant cycle
            checks++;
            if (slave_mux[1] !== master_num_t'(k) || master_mux[k] !== slave_num_t'(1)) begin
                errors++;
                $display("FAIL contention_grant%0d slave_mux[1]=%0d master_mux[%0d]=%0d exp %0d 1",
                         k, slave_mux[1], k, master_mux[k], k);
            end
            tick();  // ack cycle
            slave_ack[1] = 1'b1;
            tick();  // dead cycle
            slave_ack[1]  = 1'b0;
            master_req[k] = 1'b0;
            checks++;
            if (slave_mux[1] !== '0 || master_mux[k] !== '0) begin
                errors++;
                $display("FAIL contention_dead%0d slave_mux[1]=%0d master_mux[%0d]=%0d exp 0 0",
                         k, slave_mux[1], k, master_mux[k]);
            end
        end
    endtask

    task automatic test_parallel;
        slave_num_t  [MASTER_N:1] exp_mm;
        master_num_t [SLAVE_N:1]  exp_sm;
        do_reset();
        master_addr[1] = addr_for(3);
        master_addr[2] = addr_for(4);
        master_addr[3] = addr_for(1);
        master_req     = 4'b0111;
        exp_mm    = '0;
        exp_mm[1] = 3'd3;
        exp_mm[2] = 3'd4;
        exp_mm[3] = 3'd1;
        exp_sm    = '0;
        exp_sm[1] = 3'd3;
        exp_sm[3] = 3'd1;
        exp_sm[4] = 3'd2;
        tick();
        checks++;
        if (master_mux !== exp_mm) begin
            errors++;
            $display("FAIL parallel_master_mux got %h exp %h", master_mux, exp_mm);
        end
        checks++;
        if (slave_mux !== exp_sm) begin
            errors++;
            $display("FAIL parallel_slave_mux got %h exp %h", slave_mux, exp_sm);
        end
        slave_ack = '1;  // S2 is idle and must ignore its ack
        tick();
        slave_ack  = '0;
        master_req = '0;
        checks++;
        if (master_mux !== '0 || slave_mux !== '0) begin
            errors++;
            $display("FAIL parallel_release master_mux=%h slave_mux=%h exp 0", master_mux, slave_mux);
        end
    endtask

    task automatic test_abort;
        do_reset();
        master_addr[2] = addr_for(2);
        master_addr[3] = addr_for(2);
        master_req     = 4'b0110;
        tick();  // cycle 1
        checks++;
        if (slave_mux[2] !== master_num_t'(2) || master_mux[3] !== '0) begin
            errors++;
            $display("FAIL abort_grant slave_mux[2]=%0d master_mux[3]=%0d exp 2 0", slave_mux[2], master_mux[3]);
        end
        tick();  // cycle 2
        master_addr[2] = addr_for(4);
        tick();  // cycle 3
        checks++;
        if (master_mux[2] !== slave_num_t'(2) || slave_mux[4] !== '0) begin
            errors++;
            $display("FAIL abort_addr_change master_mux[2]=%0d slave_mux[4]=%0d exp 2 0", master_mux[2], slave_mux[4]);
        end
        tick();  // cycle 4
        tick();  // cycle 5
        master_req[2] = 1'b0;
        tick();  // cycle 6
        checks++;
        if (slave_mux[2] !== '0 || master_mux[2] !== '0) begin
            errors++;
            $display("FAIL abort_release slave_mux[2]=%0d master_mux[2]=%0d exp 0 0", slave_mux[2], master_mux[2]);
        end
        tick();  // cycle 7
        checks++;
        if (slave_mux[2] !== master_num_t'(3) || master_mux[3] !== slave_num_t'(2)) begin
            errors++;
            $display("FAIL abort_next slave_mux[2]=%0d master_mux[3]=%0d exp 3 2", slave_mux[2], master_mux[3]);
        end
        tick();  // cycle 8: ack and drop together
        slave_ack[2]  = 1'b1;
        master_req[3] = 1'b0;
        tick();  // cycle 9
        slave_ack[2] = 1'b0;
        checks++;
        if (slave_mux[2] !== '0 || master_mux[3] !== '0) begin
            errors++;
            $display("FAIL abort_ack_drop slave_mux[2]=%0d master_mux[3]=%0d exp 0 0", slave_mux[2], master_mux[3]);
        end
        master_addr[1] = addr_for(2);
        master_addr[2] = addr_for(2);
        master_req     = 4'b0011;
        tick();  // pointer is 3: search order 4,1,2
        checks++;
        if (slave_mux[2] !== master_num_t'(1)) begin
            errors++;
            $display("FAIL abort_rr_wrap slave_mux[2]=%0d exp 1", slave_mux[2]);
        end
    endtask

`ifdef CROSS_BAR_TIMEOUT_EN
    task automatic test_timeout;
        do_reset();
        master_addr[4] = addr_for(3);
        master_req[4]  = 1'b1;
        tick();  // cycle 1
        checks++;
        if (slave_mux[3] !== master_num_t'(4) || slave_timeout !== '0) begin
            errors++;
            $display("FAIL timeout_grant slave_mux[3]=%0d slave_timeout=%b exp 4 0", slave_mux[3], slave_timeout);
        end
        for (int c = 2; c <= 16; c++) begin
            tick();
            checks++;
            if (slave_mux[3] !== master_num_t'(4) || slave_timeout !== '0) begin
                errors++;
                $display("FAIL timeout_hold cycle %0d slave_mux[3]=%0d slave_timeout=%b exp 4 0",
                         c, slave_mux[3], slave_timeout);
            end
        end
        tick();  // cycle 17
        checks++;
        if (slave_mux[3] !== '0 || master_mux[4] !== '0 || slave_timeout !== 4'b0100) begin
            errors++;
            $display("FAIL timeout_release slave_mux[3]=%0d master_mux[4]=%0d slave_timeout=%b exp 0 0 0100",
                     slave_mux[3], master_mux[4], slave_timeout);
        end
        master_req[4] = 1'b0;
        tick();  // cycle 18
        checks++;
        if (slave_timeout !== '0) begin
            errors++;
            $display("FAIL timeout_pulse slave_timeout=%b exp 0000", slave_timeout);
        end
    endtask
`else
    task automatic test_hold;
        do_reset();
        master_addr[4] = addr_for(3);
        master_req[4]  = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
        end
        checks++;
        if (slave_mux[3] !== master_num_t'(4) || master_mux[4] !== slave_num_t'(3)) begin
            errors++;
            $display("FAIL hold_no_limit slave_mux[3]=%0d master_mux[4]=%0d exp 4 3", slave_mux[3], master_mux[4]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_parallel();
        test_abort();
`ifdef CROSS_BAR_TIMEOUT_EN
        test_timeout();
`else
        test_hold();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cross_bar_arbiter.md
# cross_bar_arbiter

Control block that drives the select inputs (`master_mux`, `slave_mux`) of the crossbar mux datapath. It decodes each master's target slave from the request address and arbitrates round-robin per slave. It holds each connection for exactly one transaction, from grant to `slave_ack`, then releases it. It sits beside the mux: it sees the same master request/address and slave ack signals, and its registered outputs steer the mux.

## Interface
Parameters (localparams taken from `cross_bar_pkg`):
- `MASTER_N`, package value: number of masters; indices are 1..MASTER_N.
- `SLAVE_N`, package value: number of slaves; indices are 1..SLAVE_N. Must be a power of two.
- `addr_t`, `master_num_t`, `slave_num_t`, package types. Value 0 of a num type means "no connect".
- `SEL_W`, `$clog2(SLAVE_N)`: number of address MSBs used for slave decode.
- `TIMEOUT_CYCLES`, 256: watchdog limit. Used only with the configuration macro.

Ports:
- `clk` input 1: single clock, all state on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `master_req` input [MASTER_N:1]: per-master request, held until the master sees its ack.
- `master_addr` input addr_t [MASTER_N:1]: request address. Target slave = `addr[$bits(addr_t)-1 -: SEL_W] + 1`.
- `slave_ack` input [SLAVE_N:1]: raw slave ack, one-cycle pulse that ends a transaction.
- `master_mux` output slave_num_t [MASTER_N:1]: slave connected to each master, 0 = none. Registered.
- `slave_mux` output master_num_t [SLAVE_N:1]: master connected to each slave, 0 = none. Registered.
- `slave_timeout` output [SLAVE_N:1]: watchdog release pulse. Present only with `CROSS_BAR_TIMEOUT_EN`.

## Operation
- There is one independent FSM per slave s, with states IDLE and BUSY. Each slave also keeps a round-robin pointer `last[s]` (master_num_t).
- A candidate for slave s is any master m with `master_req[m]=1` whose decoded target is s and whose `master_mux[m]==0`.
- IDLE → BUSY happens when at least one candidate exists. The winner is the first candidate found searching m = last[s]+1 … MASTER_N, then 1 … last[s].
  - On this transition the block sets `slave_mux[s]=m` and `master_mux[m]=s`.
- BUSY → IDLE happens on `slave_ack[s]=1`. The block clears `slave_mux[s]` and `master_mux[m]`, and sets `last[s]=m`.
- Abort: in BUSY, if `master_req[m]` of the granted master is 0 while `slave_ack[s]=0`, the FSM goes to IDLE and clears both mux entries. It also sets `last[s]=m`.
- Ack and request drop in the same cycle count as a normal completion.
- Each master targets one slave at a time, so at most one slave can grant a given master. `master_mux` therefore never has conflicts.
- A change of `master_addr` while BUSY is ignored until release.
- Arbitration happens only in IDLE. A BUSY slave never re-arbitrates.

## Timing
- Reset (asynchronous, any time, including mid-transaction):
  - all `master_mux` and `slave_mux` entries = 0;
  - all FSMs = IDLE;
  - `last[s] = MASTER_N`, so master 1 has first priority;
  - `slave_timeout` = 0;
  - watchdog counters = 0.
- Grant latency: request present in cycle 0 to an IDLE slave → mux entries valid in cycle 1.
- Release: `slave_ack` in cycle k → mux entries 0 in cycle k+1.
  - The next grant on that slave is earliest valid in cycle k+2.
  - This gives one guaranteed dead cycle, so a master's held request in its ack cycle is never re-granted.
- Slaves arbitrate in parallel. N independent master/slave pairs can all be granted in the same cycle.
- `slave_ack[s]` while IDLE is ignored.

## Configuration
- `CROSS_BAR_TIMEOUT_EN` defined:
  - Each slave has a counter of width `$clog2(TIMEOUT_CYCLES)+1`, cleared on entry to BUSY and incremented each BUSY cycle without ack.
  - When the counter reaches `TIMEOUT_CYCLES-1` with no ack, that edge releases the grant exactly like an abort.
  - `slave_timeout[s]` is 1 for exactly the first cycle in which the mux entries read 0.
- `CROSS_BAR_TIMEOUT_EN` not defined: no counters and no `slave_timeout` port. BUSY lasts until ack or abort, with no limit.

## Test plan
- Reset: assert `rst_n=0` mid-grant → all mux outputs 0 immediately. After release, M1 and M2 both request S1 → M1 is granted first.
- Single transfer: M1 addr MSBs = 2'b01 in cycle 0 (SLAVE_N=4) → `slave_mux[2]=1` and `master_mux[1]=2` in cycle 1. `slave_ack[2]` in cycle 3 → both 0 in cycle 4.
- Contention: M1–M4 all target S1 from cycle 0, each acked one cycle after its grant and then dropping its request → grant order 1, 2, 3, 4 with one dead cycle between grants.
- Parallel: M1→S3, M2→S4, M3→S1 in the same cycle → all three pairs granted in cycle 1, with no interference.
- Abort: M2 granted on S2 drops `master_req` in cycle 5 with no ack → `slave_mux[2]=0` in cycle 6. M3 requesting S2 is granted in cycle 7.
- Timeout (macro on, `TIMEOUT_CYCLES=16`): granted in cycle 1, never acked → release with `slave_timeout[s]=1` in cycle 17 only. With the macro off, the grant is held indefinitely.
